// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA raster timing generator. It produces the
// scan coordinates and the blank/sync/frame decodes, all registered and aligned.
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       sync,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q, blank_d;
    logic       frame_start_q, frame_start_d;
    logic [7:0] frame_count_q, frame_count_d;
    logic       line_end;
    logic       frame_wrap;

    // Next raster position: hc wraps each line, vc wraps each frame
    always_comb begin
        line_end   = (hc_q == H_LAST);
        frame_wrap = line_end && (vc_q == V_LAST);
        hc_d       = hc_q + 10'd1;
        vc_d       = vc_q;
        if (line_end) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
        end
    end

    // Decode from the next position so outputs line up with the coordinates
    always_comb begin
        hs_d          = !((hc_d >= HS_START) && (hc_d < HS_END));
        vs_d          = !((vc_d >= VS_START) && (vc_d < VS_END));
        blank_d       = (hc_d < H_VIS) && (vc_d < V_VIS);
        frame_start_d = frame_wrap;
        frame_count_d = frame_wrap ? frame_count_q + 8'd1 : frame_count_q;
    end

    // State registers; reset parks the raster at (0,0) without a frame wrap
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hc_q          <= '0;
            vc_q          <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign sync        = 1'b0;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a shrunk-timing instance covers frame and counter
// wraps quickly, a default 640x480 instance covers the real line timing.
module tb_vga_sync_gen;

    localparam int unsigned SH_V = 6, SH_F = 1, SH_S = 2, SH_B = 1;
    localparam int unsigned SV_V = 4, SV_F = 1, SV_S = 2, SV_B = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [9:0] s_x, s_y, d_x, d_y;
    logic       s_hs, s_vs, s_bl, s_sy, s_fs;
    logic       d_hs, d_vs, d_bl, d_sy, d_fs;
    logic [7:0] s_fc, d_fc;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  edges    = 0;
    longint t     = 0;

    vga_sync_gen #(
        .H_VISIBLE(SH_V), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
        .V_VISIBLE(SV_V), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B)
    ) u_small (
        .vga_clk(clk), .reset(rst), .DrawX(s_x), .DrawY(s_y), .hs(s_hs), .vs(s_vs),
        .blank(s_bl), .sync(s_sy), .frame_start(s_fs), .frame_count(s_fc)
    );

    vga_sync_gen u_dflt (
        .vga_clk(clk), .reset(rst), .DrawX(d_x), .DrawY(d_y), .hs(d_hs), .vs(d_vs),
        .blank(d_bl), .sync(d_sy), .frame_start(d_fs), .frame_count(d_fc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
        end
    endtask

    // Expected outputs after t edges since reset release, from raster arithmetic
    task automatic model_check(input string tag,
                               input int hv, input int hf, input int hsw, input int hb,
                               input int vv, input int vf, input int vsw, input int vb,
                               input longint tt,
                               input logic [9:0] x, input logic [9:0] y,
                               input logic h, input logic v, input logic bl,
                               input logic sy, input logic fs, input logic [7:0] fc);
        longint ht, vt, ft, ex, ey;
        ht = longint'(hv + hf + hsw + hb);
        vt = longint'(vv + vf + vsw + vb);
        ft = ht * vt;
        ex = tt % ht;
        ey = (tt / ht) % vt;
        check({tag, " DrawX"}, 64'(x), 64'(ex));
        check({tag, " DrawY"}, 64'(y), 64'(ey));
        check({tag, " hs"}, 64'(h), 64'(!(ex >= hv + hf && ex < hv + hf + hsw)));
        check({tag, " vs"}, 64'(v), 64'(!(ey >= vv + vf && ey < vv + vf + vsw)));
        check({tag, " blank"}, 64'(bl), 64'(ex < hv && ey < vv));
        check({tag, " sync"}, 64'(sy), 64'(0));
        check({tag, " frame_start"}, 64'(fs), 64'(tt > 0 && (tt % ft) == 0));
        check({tag, " frame_count"}, 64'(fc), 64'((tt / ft) % 256));
    endtask

    task automatic reset_check(input string tag,
                               input logic [9:0] x, input logic [9:0] y,
                               input logic h, input logic v, input logic bl,
                               input logic fs, input logic [7:0] fc);
        check({tag, " rst DrawX"}, 64'(x), 64'(0));
        check({tag, " rst DrawY"}, 64'(y), 64'(0));
        check({tag, " rst hs"}, 64'(h), 64'(1));
        check({tag, " rst vs"}, 64'(v), 64'(1));
        check({tag, " rst blank"}, 64'(bl), 64'(1));
        check({tag, " rst frame_start"}, 64'(fs), 64'(0));
        check({tag, " rst frame_count"}, 64'(fc), 64'(0));
    endtask

    // Per-cycle compare of both instances against the model, on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            reset_check("small", s_x, s_y, s_hs, s_vs, s_bl, s_fs, s_fc);
            reset_check("dflt", d_x, d_y, d_hs, d_vs, d_bl, d_fs, d_fc);
            t = 0;
        end else begin
            model_check("small", SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B,
                        t, s_x, s_y, s_hs, s_vs, s_bl, s_sy, s_fs, s_fc);
            model_check("dflt", 640, 16, 96, 48, 480, 10, 2, 33,
                        t, d_x, d_y, d_hs, d_vs, d_bl, d_sy, d_fs, d_fc);
            t++;
        end
    end

    task automatic advance_to(input int n);
        while (edges < n) begin
            @(posedge clk);
            edges++;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset_check("lit small", s_x, s_y, s_hs, s_vs, s_bl, s_fs, s_fc);
        reset_check("lit dflt", d_x, d_y, d_hs, d_vs, d_bl, d_fs, d_fc);
        rst   = 1'b0;
        edges = 0;
        #1;
        check("lit first blank", 64'(d_bl), 64'(1));
        check("lit first DrawX", 64'(d_x), 64'(0));

        // Shrunk raster: H total 10 (hs low 7..8), V total 8 (vs low 5..6), frame 80
        advance_to(7);
        check("lit s hs fall x", 64'(s_x), 64'(7));
        check("lit s hs fall", 64'(s_hs), 64'(0));
        advance_to(9);
        check("lit s hs rise", 64'(s_hs), 64'(1));
        advance_to(40);
        check("lit s line4 y", 64'(s_y), 64'(4));
        check("lit s line4 blank", 64'(s_bl), 64'(0));
        advance_to(50);
        check("lit s vs low", 64'(s_vs), 64'(0));
        advance_to(70);
        check("lit s vs high", 64'(s_vs), 64'(1));
        advance_to(80);
        check("lit s wrap fs", 64'(s_fs), 64'(1));
        check("lit s wrap fc", 64'(s_fc), 64'(1));
        check("lit s wrap xy", 64'({s_x, s_y}), 64'(0));
        advance_to(81);
        check("lit s fs one cycle", 64'(s_fs), 64'(0));

        // Full-size line timing
        advance_to(639);
        check("lit d blank 639", 64'(d_bl), 64'(1));
        advance_to(640);
        check("lit d blank fall", 64'(d_bl), 64'(0));
        check("lit d x 640", 64'(d_x), 64'(640));
        advance_to(655);
        check("lit d hs 655", 64'(d_hs), 64'(1));
        advance_to(656);
        check("lit d hs fall", 64'(d_hs), 64'(0));
        advance_to(751);
        check("lit d hs 751", 64'(d_hs), 64'(0));
        advance_to(752);
        check("lit d hs rise", 64'(d_hs), 64'(1));
        advance_to(799);
        check("lit d x 799", 64'(d_x), 64'(799));
        advance_to(800);
        check("lit d line1 x", 64'(d_x), 64'(0));
        check("lit d line1 y", 64'(d_y), 64'(1));
        check("lit d line1 blank", 64'(d_bl), 64'(1));

        // Frame counter wrap on the small raster
        advance_to(255 * 80);
        check("lit s fc 255", 64'(s_fc), 64'(255));
        check("lit s fs 255", 64'(s_fs), 64'(1));
        advance_to(256 * 80 - 1);
        check("lit s fc before wrap", 64'(s_fc), 64'(255));
        advance_to(256 * 80);
        check("lit s fc wrap 0", 64'(s_fc), 64'(0));
        check("lit s fs wrap 0", 64'(s_fs), 64'(1));

        // Mid-frame asynchronous reset at (3,2) with frame_count 3
        advance_to(259 * 80 + 2 * 10 + 3);
        check("lit s pre-rst x", 64'(s_x), 64'(3));
        check("lit s pre-rst y", 64'(s_y), 64'(2));
        check("lit s pre-rst fc", 64'(s_fc), 64'(3));
        #2;
        rst = 1'b1;
        #1;
        reset_check("async small", s_x, s_y, s_hs, s_vs, s_bl, s_fs, s_fc);
        reset_check("async dflt", d_x, d_y, d_hs, d_vs, d_bl, d_fs, d_fc);
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b0;
        edges = 0;
        advance_to(79);
        check("lit s restart no fs", 64'(s_fs), 64'(0));
        check("lit s restart fc", 64'(s_fc), 64'(0));
        advance_to(80);
        check("lit s restart fs", 64'(s_fs), 64'(1));
        check("lit s restart fc1", 64'(s_fc), 64'(1));

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
